// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle shared by a register-bank slave and its master.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank: independent write and read paths, byte-strobed writes,
// parallel register view and a one-cycle write pulse per register.
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARSTN,
    axi_lite_reg_slave_if.slave            bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT,
    output logic [NUM_REGS-1:0]            REG_WR
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return int'({1'b0, idx}) < NUM_REGS;
    endfunction

    wstate_e                              wstate_q, wstate_d;
    logic                                 rdy_en_q;
    logic [ADDR_WIDTH-1:0]                awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic [STRB_W-1:0]                    wstrb_q, wstrb_d;
    logic [1:0]                           bresp_q, bresp_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q;
    logic [NUM_REGS-1:0]                  reg_wr_q;
    logic                                 rvalid_q;
    logic [DATA_WIDTH-1:0]                rdata_q;
    logic [1:0]                           rresp_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic [IDX_W-1:0]      c_idx, ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Readies stay low through reset and become live on the first edge after release.
    assign bus.AWREADY = rdy_en_q && (wstate_q == W_IDLE || wstate_q == W_HAVE_W);
    assign bus.WREADY  = rdy_en_q && (wstate_q == W_IDLE || wstate_q == W_HAVE_AW);
    assign bus.BVALID  = (wstate_q == W_RESP);
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = rdy_en_q && !rvalid_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign REGS_OUT    = regs_q;
    assign REG_WR      = reg_wr_q;

    assign aw_hs  = bus.AWVALID && bus.AWREADY;
    assign w_hs   = bus.WVALID  && bus.WREADY;
    assign ar_hs  = bus.ARVALID && bus.ARREADY;
    assign c_idx  = c_addr[ADDR_WIDTH-1:LSB];
    assign ar_idx = bus.ARADDR[ADDR_WIDTH-1:LSB];

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        c_addr   = awaddr_q;
        c_data   = wdata_q;
        c_strb   = wstrb_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_addr = bus.AWADDR;
                    c_data = bus.WDATA;
                    c_strb = bus.WSTRB;
                end else if (aw_hs) begin
                    awaddr_d = bus.AWADDR;
                    wstate_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d  = bus.WDATA;
                    wstrb_d  = bus.WSTRB;
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = bus.WDATA;
                    c_strb = bus.WSTRB;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_addr = bus.AWADDR;
                end
            end
            W_RESP: begin
                if (bus.BREADY) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
        if (commit) begin
            wstate_d = W_RESP;
            bresp_d  = in_range(c_idx) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            wstate_q <= W_IDLE;
            rdy_en_q <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            rdy_en_q <= 1'b1;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
        end
    end

    // Out-of-range indices match no register, so they neither write nor pulse REG_WR.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            regs_q   <= '0;
            reg_wr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr_q[i] <= commit && (c_idx == IDX_W'(i));
                for (int k = 0; k < STRB_W; k++) begin
                    if (commit && (c_idx == IDX_W'(i)) && c_strb[k])
                        regs_q[i][8*k +: 8] <= c_data[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    // Read samples regs_q before this edge's write lands, so a same-edge read sees old data.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && bus.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule
